// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: product motor / nickel hopper sequencer with stock and coin tracking.
// Optional watchdog on motor_done and coin_seen is built in when VEND_TIMEOUT_EN is defined.
module vend_dispense_ctrl #(
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W = 4,
  parameter int COIN_INIT = 20,
  parameter int COIN_W = 6
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT = 200
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               P,
  input  logic               C,
  input  logic [3:0]         change_nickels,
  input  logic               restock,
  input  logic               motor_done,
  input  logic               coin_seen,
  output logic               motor_on,
  output logic               eject,
  output logic               busy,
  output logic               sold_out,
  output logic               fault,
  output logic [STOCK_W-1:0] stock_cnt,
  output logic [COIN_W-1:0]  coin_cnt
);
  typedef enum logic [2:0] {IDLE, VEND, CHG_EJECT, CHG_WAIT, FAULT} state_t;
  state_t state, state_nxt;
  logic [3:0] remaining, remaining_nxt;
  logic [STOCK_W-1:0] stock_nxt;
  logic [COIN_W-1:0] coin_nxt;
  logic tmo_hit;
`ifdef VEND_TIMEOUT_EN
  logic [7:0] tmo;
  assign tmo_hit = tmo == 8'(TIMEOUT - 1);
  // watchdog: counts cycles spent waiting for a motor/coin response, cleared by any response
  always_ff @(posedge clock)
    if (!reset_n) tmo <= '0;
    else tmo <= ((state == VEND && !motor_done) || (state == CHG_WAIT && !coin_seen)) && !tmo_hit ? tmo + 8'd1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  // next state and counter updates; registered outputs are derived from the next state
  always_comb begin
    state_nxt = state;
    remaining_nxt = remaining;
    stock_nxt = stock_cnt;
    coin_nxt = coin_cnt;
    case (state)
      IDLE:
        if (P && !sold_out) begin
          state_nxt = VEND;
          remaining_nxt = C ? change_nickels : 4'd0;
        end else if (restock && !P) begin
          stock_nxt = STOCK_W'(STOCK_INIT);
          coin_nxt = COIN_W'(COIN_INIT);
        end
      VEND:
        if (motor_done) begin
          state_nxt = remaining != 4'd0 ? CHG_EJECT : IDLE;
          stock_nxt = stock_cnt - STOCK_W'(stock_cnt != '0);
        end else if (tmo_hit) state_nxt = FAULT;
      CHG_EJECT: state_nxt = coin_cnt == '0 ? FAULT : CHG_WAIT;
      CHG_WAIT:
        if (coin_seen) begin
          state_nxt = remaining <= 4'd1 ? IDLE : CHG_EJECT;
          remaining_nxt = remaining - 4'(remaining != 4'd0);
          coin_nxt = coin_cnt - COIN_W'(coin_cnt != '0);
        end else if (tmo_hit) state_nxt = FAULT;
      default: ;
    endcase
  end
  // state, counters and all outputs registered; eject fires only on the CHG_EJECT -> CHG_WAIT step
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= IDLE;
      remaining <= '0;
      stock_cnt <= STOCK_W'(STOCK_INIT);
      coin_cnt <= COIN_W'(COIN_INIT);
      sold_out <= STOCK_INIT == 0;
      motor_on <= 1'b0;
      eject <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      remaining <= remaining_nxt;
      stock_cnt <= stock_nxt;
      coin_cnt <= coin_nxt;
      sold_out <= stock_nxt == '0;
      motor_on <= state_nxt == VEND;
      eject <= state == CHG_EJECT && state_nxt == CHG_WAIT;
      busy <= state_nxt != IDLE;
      fault <= state_nxt == FAULT;
    end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: scenario tasks plus randomized transactions against a counter-level model.
module tb_vend_dispense_ctrl;
  logic clock = 1'b0, reset_n = 1'b0, P = 1'b0, C = 1'b0, restock = 1'b0;
  logic motor_done = 1'b0, coin_seen = 1'b0;
  logic [3:0] change_nickels = 4'd0;
  logic motor_on, eject, busy, sold_out, fault;
  logic [3:0] stock_cnt;
  logic [5:0] coin_cnt;
  int total = 0, bad = 0;
  int m_stock, m_coin;

  vend_dispense_ctrl dut (
    .clock(clock), .reset_n(reset_n), .P(P), .C(C), .change_nickels(change_nickels),
    .restock(restock), .motor_done(motor_done), .coin_seen(coin_seen),
    .motor_on(motor_on), .eject(eject), .busy(busy), .sold_out(sold_out), .fault(fault),
    .stock_cnt(stock_cnt), .coin_cnt(coin_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    P = 0; C = 0; change_nickels = 0; restock = 0; motor_done = 0; coin_seen = 0;
    reset_n = 0; tick(); tick(); reset_n = 1;
  endtask

  // issues one request and plays the motor/hopper; lat = cycles after the P edge until busy is low or fault is up
  task automatic vend(input bit c, input int ch, input int md, input int cd, input bit stray,
                      output int ej, output int mon, output int lat, output bit done);
    int cw;
    cw = 0; ej = 0; mon = 0; lat = 0; done = 0;
    P = 1; C = c; change_nickels = 4'(ch); tick();
    restock = 0;
    for (int t = 0; t < 2000; t++) begin
      motor_done = 0; coin_seen = 0; P = 0; C = 0; change_nickels = 0;
      if (!busy || fault) begin lat = t; done = 1; break; end
      if (motor_on) begin mon++; if (mon == md) motor_done = 1; end
      if (eject) begin ej++; cw = cd; end
      else if (cw > 0) begin cw--; if (cw == 0) coin_seen = 1; end
      if (stray && ej == 1 && cw == cd - 1 && !eject) begin P = 1; C = 1; change_nickels = 4'd7; motor_done = 1; end
      tick();
    end
    P = 0; C = 0; change_nickels = 0; motor_done = 0; coin_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (motor_on !== 1'b0) begin bad++; $display("FAIL rst_motor_on: got %b want 0", motor_on); end
    total++; if (eject !== 1'b0) begin bad++; $display("FAIL rst_eject: got %b want 0", eject); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
    total++; if (sold_out !== 1'b0) begin bad++; $display("FAIL rst_sold_out: got %b want 0", sold_out); end
    total++; if (stock_cnt !== 4'd8) begin bad++; $display("FAIL rst_stock: got %0d want 8", stock_cnt); end
    total++; if (coin_cnt !== 6'd20) begin bad++; $display("FAIL rst_coin: got %0d want 20", coin_cnt); end
  endtask

  task automatic test_no_change();
    int ej, mon, lat; bit done;
    vend(0, 0, 5, 1, 0, ej, mon, lat, done);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL nochg_done: got %b want 1", done); end
    total++; if (mon != 5) begin bad++; $display("FAIL nochg_motor_cycles: got %0d want 5", mon); end
    total++; if (lat != 5) begin bad++; $display("FAIL nochg_busy_drop: got %0d want 5", lat); end
    total++; if (ej != 0) begin bad++; $display("FAIL nochg_ejects: got %0d want 0", ej); end
    total++; if (stock_cnt !== 4'd7) begin bad++; $display("FAIL nochg_stock: got %0d want 7", stock_cnt); end
    total++; if (coin_cnt !== 6'd20) begin bad++; $display("FAIL nochg_coin: got %0d want 20", coin_cnt); end
  endtask

  task automatic test_change();
    int ej, mon, lat; bit done;
    vend(1, 2, 3, 3, 0, ej, mon, lat, done);
    total++; if (ej != 2) begin bad++; $display("FAIL chg_ejects: got %0d want 2", ej); end
    total++; if (lat != 3 + 2 * (3 + 2)) begin bad++; $display("FAIL chg_busy_drop: got %0d want %0d", lat, 3 + 2 * 5); end
    total++; if (coin_cnt !== 6'd18) begin bad++; $display("FAIL chg_coin: got %0d want 18", coin_cnt); end
    total++; if (stock_cnt !== 4'd6) begin bad++; $display("FAIL chg_stock: got %0d want 6", stock_cnt); end
    vend(1, 0, 2, 1, 0, ej, mon, lat, done);
    total++; if (ej != 0 || lat != 2) begin bad++; $display("FAIL chg_zero: got ej=%0d lat=%0d want ej=0 lat=2", ej, lat); end
    total++; if (stock_cnt !== 4'd5) begin bad++; $display("FAIL chg_zero_stock: got %0d want 5", stock_cnt); end
  endtask

  task automatic test_sold_out();
    int ej, mon, lat; bit done;
    C = 1; change_nickels = 4'd5; tick(); C = 0; change_nickels = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL c_without_p: got busy=%b want 0", busy); end
    restock = 1;
    vend(0, 0, 1, 1, 0, ej, mon, lat, done);
    total++; if (stock_cnt !== 4'd4 || coin_cnt !== 6'd18) begin bad++; $display("FAIL p_beats_restock: got stock=%0d coin=%0d want 4 18", stock_cnt, coin_cnt); end
    repeat (4) vend(0, 0, 2, 1, 0, ej, mon, lat, done);
    total++; if (stock_cnt !== 4'd0) begin bad++; $display("FAIL so_stock: got %0d want 0", stock_cnt); end
    total++; if (sold_out !== 1'b1) begin bad++; $display("FAIL so_flag: got %b want 1", sold_out); end
    vend(0, 0, 2, 1, 0, ej, mon, lat, done);
    total++; if (mon != 0 || lat != 0) begin bad++; $display("FAIL so_ignored: got motor=%0d lat=%0d want 0 0", mon, lat); end
    restock = 1; tick(); restock = 0;
    total++; if (stock_cnt !== 4'd8 || coin_cnt !== 6'd20) begin bad++; $display("FAIL restock: got stock=%0d coin=%0d want 8 20", stock_cnt, coin_cnt); end
    total++; if (sold_out !== 1'b0) begin bad++; $display("FAIL restock_sold_out: got %b want 0", sold_out); end
  endtask

  task automatic test_empty_hopper();
    int ej, mon, lat; bit done;
    do_reset();
    vend(1, 15, 1, 1, 0, ej, mon, lat, done);
    vend(1, 4, 1, 1, 0, ej, mon, lat, done);
    total++; if (coin_cnt !== 6'd1) begin bad++; $display("FAIL hop_drain: got %0d want 1", coin_cnt); end
    vend(1, 3, 1, 2, 0, ej, mon, lat, done);
    total++; if (ej != 1) begin bad++; $display("FAIL hop_ejects: got %0d want 1", ej); end
    total++; if (fault !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL hop_fault: got fault=%b busy=%b want 1 1", fault, busy); end
    total++; if (coin_cnt !== 6'd0) begin bad++; $display("FAIL hop_coin: got %0d want 0", coin_cnt); end
    P = 1; tick(); P = 0; restock = 1; tick(); restock = 0; tick();
    total++; if (motor_on !== 1'b0 || eject !== 1'b0) begin bad++; $display("FAIL fault_outputs: got motor=%b eject=%b want 0 0", motor_on, eject); end
    total++; if (stock_cnt !== 4'd5 || coin_cnt !== 6'd0 || fault !== 1'b1) begin bad++; $display("FAIL fault_sticky: got stock=%0d coin=%0d fault=%b want 5 0 1", stock_cnt, coin_cnt, fault); end
    do_reset();
    total++; if (fault !== 1'b0 || busy !== 1'b0 || coin_cnt !== 6'd20) begin bad++; $display("FAIL fault_clear: got fault=%b busy=%b coin=%0d want 0 0 20", fault, busy, coin_cnt); end
  endtask

  task automatic test_timeout();
    int ej, mon, lat; bit done;
    do_reset();
    vend(0, 0, 0, 1, 0, ej, mon, lat, done);
`ifdef VEND_TIMEOUT_EN
    total++; if (done !== 1'b1 || lat != 200) begin bad++; $display("FAIL tmo_fault_time: got done=%b lat=%0d want 1 200", done, lat); end
    total++; if (fault !== 1'b1 || motor_on !== 1'b0) begin bad++; $display("FAIL tmo_fault: got fault=%b motor=%b want 1 0", fault, motor_on); end
`else
    total++; if (done !== 1'b0) begin bad++; $display("FAIL notmo_wait: got done=%b lat=%0d want still busy", done, lat); end
    total++; if (busy !== 1'b1 || motor_on !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL notmo_state: got busy=%b motor=%b fault=%b want 1 1 0", busy, motor_on, fault); end
`endif
    do_reset();
  endtask

  task automatic test_back_to_back();
    int ej, mon, lat, cnt; bit seen;
    bit done;
    motor_done = 1; coin_seen = 1; tick(); motor_done = 0; coin_seen = 0; tick();
    total++; if (stock_cnt !== 4'd8 || coin_cnt !== 6'd20 || busy !== 1'b0) begin bad++; $display("FAIL stray_idle: got stock=%0d coin=%0d busy=%b want 8 20 0", stock_cnt, coin_cnt, busy); end
    vend(1, 2, 2, 3, 1, ej, mon, lat, done);
    total++; if (ej != 2 || lat != 2 + 2 * 5) begin bad++; $display("FAIL b2b_seq: got ej=%0d lat=%0d want 2 12", ej, lat); end
    total++; if (stock_cnt !== 4'd7 || coin_cnt !== 6'd18) begin bad++; $display("FAIL b2b_counts: got stock=%0d coin=%0d want 7 18", stock_cnt, coin_cnt); end
    P = 1; C = 1; change_nickels = 4'd3; tick(); P = 0; C = 0; change_nickels = 0;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      motor_done = motor_on;
      if (eject) seen = 1; else tick();
    end
    motor_done = 0;
    total++; if (!seen) begin bad++; $display("FAIL midrst_eject: got no eject want one"); end
    reset_n = 0; tick(); reset_n = 1;
    total++; if (motor_on !== 1'b0 || eject !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL midrst_out: got %b%b%b%b want 0000", motor_on, eject, busy, fault); end
    total++; if (stock_cnt !== 4'd8 || coin_cnt !== 6'd20 || sold_out !== 1'b0) begin bad++; $display("FAIL midrst_cnt: got stock=%0d coin=%0d want 8 20", stock_cnt, coin_cnt); end
    cnt = 0;
    repeat (10) begin coin_seen = 1; tick(); if (eject) cnt++; end
    coin_seen = 0;
    total++; if (cnt != 0 || coin_cnt !== 6'd20) begin bad++; $display("FAIL midrst_quiet: got ejects=%0d coin=%0d want 0 20", cnt, coin_cnt); end
  endtask

  task automatic test_random();
    int ej, mon, lat, r, ch, md, cd, exp_ej, exp_lat, exp_mon; bit c, done;
    do_reset(); m_stock = 8; m_coin = 20;
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0 || (m_stock == 0 && r < 5) || m_coin < 4) begin
        restock = 1; tick(); restock = 0; m_stock = 8; m_coin = 20;
        total++; if (stock_cnt !== 4'(m_stock) || coin_cnt !== 6'(m_coin)) begin bad++; $display("FAIL rnd_restock: got %0d %0d want %0d %0d", stock_cnt, coin_cnt, m_stock, m_coin); end
      end else begin
        c = 1'($urandom_range(0, 1)); ch = $urandom_range(0, m_coin < 15 ? m_coin : 15);
        md = $urandom_range(1, 8); cd = $urandom_range(1, 4);
        vend(c, ch, md, cd, 0, ej, mon, lat, done);
        exp_ej = (m_stock != 0 && c) ? ch : 0;
        exp_mon = m_stock != 0 ? md : 0;
        exp_lat = m_stock != 0 ? md + exp_ej * (cd + 2) : 0;
        if (m_stock != 0) begin m_stock--; m_coin -= exp_ej; end
        total++; if (!done || ej != exp_ej || mon != exp_mon || lat != exp_lat) begin bad++; $display("FAIL rnd_txn: got done=%b ej=%0d mon=%0d lat=%0d want 1 %0d %0d %0d", done, ej, mon, lat, exp_ej, exp_mon, exp_lat); end
        total++; if (stock_cnt !== 4'(m_stock) || coin_cnt !== 6'(m_coin) || sold_out !== (m_stock == 0) || fault !== 1'b0) begin bad++; $display("FAIL rnd_state: got stock=%0d coin=%0d so=%b fault=%b want %0d %0d", stock_cnt, coin_cnt, sold_out, fault, m_stock, m_coin); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_change();
    test_change();
    test_sold_out();
    test_empty_hopper();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Receives the product-dispense (P) and change (C) requests from the 25c vending FSM.
- Drives the product motor and the nickel coin hopper, each with a completion handshake.
- Tracks product stock and hopper coin inventory.
- Flags sold-out, hopper-empty and watchdog faults back to the front panel.

Parameters:
STOCK_INIT, 8, products loaded on reset/restock
STOCK_W, 4, stock counter width
COIN_INIT, 20, nickels loaded on reset/restock
COIN_W, 6, coin counter width
TIMEOUT, 200, max cycles waiting for motor_done or coin_seen (8-bit counter)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
P  in  1  dispense request, sampled high for one cycle
C  in  1  change request, valid with P
change_nickels  in  4  change owed, in nickels; sampled when P&C
restock  in  1  reload stock_cnt/coin_cnt; honoured in IDLE only
motor_done  in  1  product motor finished; 1-cycle pulse
coin_seen  in  1  hopper coin-exit sensor; 1-cycle pulse
motor_on  out  1  product motor enable
eject  out  1  one-cycle hopper eject pulse, one nickel per pulse
busy  out  1  request in progress
sold_out  out  1  stock_cnt==0
fault  out  1  sticky fault
stock_cnt  out  STOCK_W  products remaining
coin_cnt  out  COIN_W  nickels remaining

Behaviour:
Clock and reset:
- Reset is reset_n, synchronous, active-low; clock is clock.
- On reset: state=IDLE; motor_on=eject=busy=fault=0; stock_cnt=STOCK_INIT; coin_cnt=COIN_INIT; remaining=0; tmo=0.
- Reset mid-operation aborts immediately with no further eject pulses.
- All outputs are registered. sold_out is registered from stock_cnt.

States:
- IDLE:
  - P=1 and sold_out=0 at edge k: latch remaining = C ? change_nickels : 0. Go to VEND. motor_on=busy=1 from cycle k+1.
  - P=1 and sold_out=1: ignored, stays IDLE.
  - C without P: ignored.
  - restock=1 and P=0: reload both counters.
  - restock=1 with P=1: P wins, restock ignored.
- VEND:
  - motor_on=1. tmo increments each cycle.
  - motor_done=1: motor_on=0, stock_cnt-=1, tmo=0. Go to CHG_EJECT if remaining!=0, else IDLE (busy=0 next cycle).
  - tmo reaches TIMEOUT: go to FAULT. If motor_done arrives on the same cycle, motor_done wins.
- CHG_EJECT:
  - coin_cnt==0: go to FAULT, no pulse.
  - Otherwise: eject=1 for exactly one cycle, go to CHG_WAIT.
- CHG_WAIT:
  - tmo counts. coin_seen=1: remaining-=1, coin_cnt-=1, tmo=0.
  - remaining reaches 0: go to IDLE. Otherwise go back to CHG_EJECT.
  - Timeout goes to FAULT; coin_seen wins a tie.
- FAULT:
  - fault=1, busy=1, motor_on=0, eject=0.
  - Sticky until reset. P, C and restock are ignored.

Boundary and ordering rules:
- P while busy is ignored (not queued).
- Stray motor_done or coin_seen outside its waiting state is ignored.
- Counters never wrap below 0. Decrement only happens in the states above.
- change_nickels=0 with C=1 behaves as no change.
- Minimum latency, P to busy low with no change: 2 cycles + motor response time.

Optional Feature:
VEND_TIMEOUT_EN
- Defined: tmo counter and the timeout-to-FAULT transitions exist as described.
- Undefined: no tmo counter; VEND and CHG_WAIT wait indefinitely.
- FAULT is then reachable only via the empty hopper (coin_cnt==0 in CHG_EJECT).

Test Plan:
- Reset, P=1 C=0; motor_done 5 cycles later -> motor_on high 5 cycles, stock_cnt 8->7, busy low the cycle after done, eject never pulses.
- P=1 C=1 change_nickels=2, motor_done, coin_seen 3 cycles after each eject -> exactly 2 eject pulses, coin_cnt 20->18, busy drops after the 2nd coin_seen.
- Perform 8 vends -> sold_out=1, stock_cnt=0. Then P=1 -> no motor_on. Then restock in IDLE -> stock_cnt=8, sold_out=0.
- Force coin_cnt=1, request change_nickels=3 -> one eject pulse, then fault=1 with coin_cnt=0. P is ignored until reset_n=0 clears fault.
- With VEND_TIMEOUT_EN defined, P=1 and motor_done never arrives -> fault=1 after 200 cycles in VEND. With the macro undefined, busy stays 1 indefinitely.
- Second P during CHG_WAIT plus a stray motor_done -> ignored; reset_n=0 mid-CHG_WAIT -> all outputs return to reset values next edge, counters reload.
